// File: rtl/spell_mem_pkg.sv
// Shared definitions for the spell memory request sequencer.
// Memory type codes (shared with memory blocks) and FSM state encoding.
package spell_mem_pkg;

    localparam logic [1:0] MemoryTypeData = 2'd0;
    localparam logic [1:0] MemoryTypeCode = 2'd1;
    localparam logic [1:0] MemoryTypeIo   = 2'd2;
    localparam logic [1:0] MemoryTypeRsvd = 2'd3;

    typedef enum logic [1:0] {
        StateIdle   = 2'd0,
        StateAccess = 2'd1,
        StateDone   = 2'd2
    } mem_state_t;

    // Reserved type never reaches the memory port.
    function automatic logic type_has_access(input logic [1:0] mtype);
        case (mtype)
            MemoryTypeData: return 1'b1;
            MemoryTypeCode: return 1'b1;
            MemoryTypeIo:   return 1'b1;
            MemoryTypeRsvd: return 1'b0;
            default:        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/spell_mem_rr_arb.sv
// 2-way round-robin arbiter: index 0 = fetch, index 1 = load/store.
// Ports: clock, reset, valid[1:0], advance (grant taken), grant[1:0] one-hot.
module spell_mem_rr_arb (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic prefer_ls;

    always_comb begin
        grant = 2'b00;
        unique case (1'b1)
            (valid == 2'b11): grant = prefer_ls ? 2'b10 : 2'b01;
            (valid == 2'b01): grant = 2'b01;
            (valid == 2'b10): grant = 2'b10;
            default:          grant = 2'b00;
        endcase
    end

    // Next contest goes to whichever side was not just served.
    always_ff @(posedge clock) begin
        if (reset) begin
            prefer_ls <= 1'b0;
        end else if (advance) begin
            prefer_ls <= grant[0];
        end
    end

endmodule

// File: rtl/spell_mem_ctrl.sv
// Memory request sequencer: arbitrates fetch (if_*) and load/store (ls_*)
// requests, runs one mem_* transaction at a time, returns one-cycle rsp.
// Ports: clock, reset (sync, high); if_req_*/if_rsp_*; ls_req_*/ls_rsp_*;
// mem_select/addr/data_in/memory_type/write out, mem_data_out/ready in; busy.
// Option: define SPELL_MEM_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES.
module spell_mem_ctrl
    import spell_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       if_req_valid,
    output logic       if_req_ready,
    input  logic [7:0] if_req_addr,
    output logic       if_rsp_valid,
    output logic [7:0] if_rsp_data,
    output logic       if_rsp_err,
    input  logic       ls_req_valid,
    output logic       ls_req_ready,
    input  logic [7:0] ls_req_addr,
    input  logic [7:0] ls_req_wdata,
    input  logic [1:0] ls_req_type,
    input  logic       ls_req_write,
    output logic       ls_rsp_valid,
    output logic [7:0] ls_rsp_data,
    output logic       ls_rsp_err,
    output logic       mem_select,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_data_in,
    output logic [1:0] mem_memory_type,
    output logic       mem_write,
    input  logic [7:0] mem_data_out,
    input  logic       mem_data_ready,
    output logic       busy
);

    mem_state_t state;
    logic       owner_ls;
    logic [7:0] rdata;
    logic       err;
    logic [1:0] grant;
    logic       idle;
    logic       handshake;
    logic       tmo_hit;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic [1:0] req_type;
    logic       req_write;

    assign idle = (state == StateIdle);
    assign busy = !idle;

    spell_mem_rr_arb u_arb (
        .clock   (clock),
        .reset   (reset),
        .valid   ({ls_req_valid, if_req_valid}),
        .advance (handshake),
        .grant   (grant)
    );

    assign if_req_ready = idle & grant[0];
    assign ls_req_ready = idle & grant[1];
    assign handshake = (if_req_valid & if_req_ready)
                     | (ls_req_valid & ls_req_ready);

    always_comb begin
        req_addr  = if_req_addr;
        req_wdata = 8'h00;
        req_type  = MemoryTypeCode;
        req_write = 1'b0;
        if (grant[1]) begin
            req_addr  = ls_req_addr;
            req_type  = ls_req_type;
            req_write = ls_req_write;
            req_wdata = ls_req_write ? ls_req_wdata : 8'h00;
        end
    end

`ifdef SPELL_MEM_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 4)
                      ? $clog2(TIMEOUT_CYCLES + 1) : 4;
    logic [CW-1:0] tmo_cnt;

    // Counts completed ACCESS cycles; zeroed as ACCESS is entered.
    always_ff @(posedge clock) begin
        if (reset || handshake) begin
            tmo_cnt <= '0;
        end else if (state == StateAccess) begin
            tmo_cnt <= tmo_cnt + CW'(1);
        end
    end

    assign tmo_hit = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= StateIdle;
            owner_ls        <= 1'b0;
            rdata           <= 8'h00;
            err             <= 1'b0;
            mem_select      <= 1'b0;
            mem_addr        <= 8'h00;
            mem_data_in     <= 8'h00;
            mem_memory_type <= 2'd0;
            mem_write       <= 1'b0;
            if_rsp_valid    <= 1'b0;
            if_rsp_data     <= 8'h00;
            if_rsp_err      <= 1'b0;
            ls_rsp_valid    <= 1'b0;
            ls_rsp_data     <= 8'h00;
            ls_rsp_err      <= 1'b0;
        end else begin
            if_rsp_valid <= 1'b0;
            ls_rsp_valid <= 1'b0;
            unique case (state)
                StateIdle: begin
                    if (handshake) begin
                        owner_ls        <= grant[1];
                        mem_addr        <= req_addr;
                        mem_data_in     <= req_wdata;
                        mem_memory_type <= req_type;
                        mem_write       <= req_write;
                        if (type_has_access(req_type)) begin
                            state      <= StateAccess;
                            mem_select <= 1'b1;
                        end else begin
                            state <= StateDone;
                            rdata <= 8'h00;
                            err   <= 1'b1;
                        end
                    end
                end
                StateAccess: begin
                    if (mem_data_ready) begin
                        state      <= StateDone;
                        mem_select <= 1'b0;
                        rdata      <= mem_write ? 8'h00 : mem_data_out;
                        err        <= 1'b0;
                    end else if (tmo_hit) begin
                        state      <= StateDone;
                        mem_select <= 1'b0;
                        rdata      <= 8'h00;
                        err        <= 1'b1;
                    end
                end
                StateDone: begin
                    state <= StateIdle;
                    if (owner_ls) begin
                        ls_rsp_valid <= 1'b1;
                        ls_rsp_data  <= rdata;
                        ls_rsp_err   <= err;
                    end else begin
                        if_rsp_valid <= 1'b1;
                        if_rsp_data  <= rdata;
                        if_rsp_err   <= err;
                    end
                end
                default: state <= StateIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spell_mem_ctrl.sv
// Bench for spell_mem_ctrl: transaction-timing model plus memory responder.
// Directed scenarios followed by randomized request traffic.
module tb_spell_mem_ctrl;

    logic       clock;
    logic       reset;
    logic       if_req_valid;
    logic       if_req_ready;
    logic [7:0] if_req_addr;
    logic       if_rsp_valid;
    logic [7:0] if_rsp_data;
    logic       if_rsp_err;
    logic       ls_req_valid;
    logic       ls_req_ready;
    logic [7:0] ls_req_addr;
    logic [7:0] ls_req_wdata;
    logic [1:0] ls_req_type;
    logic       ls_req_write;
    logic       ls_rsp_valid;
    logic [7:0] ls_rsp_data;
    logic       ls_rsp_err;
    logic       mem_select;
    logic [7:0] mem_addr;
    logic [7:0] mem_data_in;
    logic [1:0] mem_memory_type;
    logic       mem_write;
    logic [7:0] mem_data_out;
    logic       mem_data_ready;
    logic       busy;

    spell_mem_ctrl dut (
        .clock           (clock),
        .reset           (reset),
        .if_req_valid    (if_req_valid),
        .if_req_ready    (if_req_ready),
        .if_req_addr     (if_req_addr),
        .if_rsp_valid    (if_rsp_valid),
        .if_rsp_data     (if_rsp_data),
        .if_rsp_err      (if_rsp_err),
        .ls_req_valid    (ls_req_valid),
        .ls_req_ready    (ls_req_ready),
        .ls_req_addr     (ls_req_addr),
        .ls_req_wdata    (ls_req_wdata),
        .ls_req_type     (ls_req_type),
        .ls_req_write    (ls_req_write),
        .ls_rsp_valid    (ls_rsp_valid),
        .ls_rsp_data     (ls_rsp_data),
        .ls_rsp_err      (ls_rsp_err),
        .mem_select      (mem_select),
        .mem_addr        (mem_addr),
        .mem_data_in     (mem_data_in),
        .mem_memory_type (mem_memory_type),
        .mem_write       (mem_write),
        .mem_data_out    (mem_data_out),
        .mem_data_ready  (mem_data_ready),
        .busy            (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit started = 0;

    logic [7:0] mem_arr [0:3][0:255];

    // Transaction model: one pending request described by its handshake
    // edge p_h and memory latency p_L; all timing follows from those.
    bit         pend = 0;
    int         p_h = 0;
    int         p_L = 0;
    bit         p_ls = 0;
    logic [7:0] p_addr = 0;
    logic [7:0] p_wd = 0;
    logic [1:0] p_type = 0;
    bit         p_wr = 0;
    bit         p_t3 = 0;
    bit         p_noready = 0;
    logic [7:0] p_rd = 0;
    bit         p_err = 0;
    bit         last_if = 0;
    bit         e_busy = 0;
    bit         e_sel = 0;
    bit         e_if_rv = 0;
    bit         e_ls_rv = 0;
    logic [7:0] e_if_data = 0;
    logic [7:0] e_ls_data = 0;
    bit         e_if_err = 0;
    bit         e_ls_err = 0;
    int         next_lat = 1;
    bit         next_noready = 0;
    int         hs_n = 0;
    int         last_hs_cyc = 0;
    bit         hs_log[$];

    // Observations of the DUT taken by the compare process.
    int         if_rsp_n = 0;
    int         ls_rsp_n = 0;
    int         if_rsp_cyc = 0;
    int         ls_rsp_cyc = 0;
    logic [7:0] if_rsp_dat = 0;
    logic [7:0] ls_rsp_dat = 0;
    logic       if_rsp_er = 0;
    logic       ls_rsp_er = 0;
    bit         rsp_log[$];
    int         sel_n = 0;
    int         gap = 100;
    logic       prev_sel = 0;
    logic       sel_write = 0;
    logic [7:0] sel_din = 0;
    logic [7:0] sel_addr = 0;

`ifdef SPELL_MEM_TIMEOUT_EN
    localparam int TMO = 15;
`endif

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic model_edge();
        bit hs_if;
        bit hs_ls;
        cyc++;
        e_if_rv = 0;
        e_ls_rv = 0;
        if (reset) begin
            pend = 0;
            e_busy = 0;
            e_sel = 0;
            last_if = 0;
            e_if_data = 0;
            e_ls_data = 0;
            e_if_err = 0;
            e_ls_err = 0;
            return;
        end
        hs_if = !e_busy && if_req_valid && (!ls_req_valid || !last_if);
        hs_ls = !e_busy && ls_req_valid && (!if_req_valid || last_if);
        if (pend && cyc == p_h + p_L + 1) begin
            if (p_ls) begin
                e_ls_rv = 1;
                e_ls_data = p_rd;
                e_ls_err = p_err;
            end else begin
                e_if_rv = 1;
                e_if_data = p_rd;
                e_if_err = p_err;
            end
            pend = 0;
        end
        if (hs_if || hs_ls) begin
            pend = 1;
            p_h = cyc;
            p_ls = hs_ls;
            last_if = hs_if;
            p_addr = hs_if ? if_req_addr : ls_req_addr;
            p_type = hs_if ? 2'd1 : ls_req_type;
            p_wr = hs_if ? 1'b0 : ls_req_write;
            p_wd = (hs_ls && ls_req_write) ? ls_req_wdata : 8'h00;
            p_t3 = (p_type == 2'd3);
            p_noready = next_noready;
            if (p_t3) begin
                p_L = 0;
                p_err = 1;
                p_rd = 8'h00;
            end else if (p_noready) begin
`ifdef SPELL_MEM_TIMEOUT_EN
                p_L = TMO;
                p_err = 1;
`else
                p_L = 100000;
                p_err = 0;
`endif
                p_rd = 8'h00;
            end else begin
                p_L = next_lat;
                p_err = 0;
                p_rd = p_wr ? 8'h00 : mem_arr[p_type][p_addr];
                if (p_wr) mem_arr[p_type][p_addr] = p_wd;
            end
            hs_log.push_back(hs_ls);
            hs_n++;
            last_hs_cyc = cyc;
        end
        e_busy = pend && (cyc <= p_h + p_L);
        e_sel = pend && !p_t3 && (cyc <= p_h + p_L - 1);
    endtask

    task automatic drive_mem();
        if (e_sel && !p_noready && cyc == p_h + p_L - 1) begin
            mem_data_ready = 1'b1;
            mem_data_out = p_wr ? 8'($urandom) : p_rd;
        end else begin
            mem_data_ready = !e_sel && ($urandom_range(0, 3) == 0);
            mem_data_out = 8'($urandom);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #2;
        drive_mem();
    endtask

    always @(negedge clock) begin
        if (started) begin
            chk("busy", busy, e_busy);
            chk("mem_select", mem_select, e_sel);
            if (e_sel) begin
                chk("mem_addr", mem_addr, p_addr);
                chk("mem_data_in", mem_data_in, p_wd);
                chk("mem_type", mem_memory_type, p_type);
                chk("mem_write", mem_write, p_wr);
            end
            chk("if_rsp_valid", if_rsp_valid, e_if_rv);
            chk("ls_rsp_valid", ls_rsp_valid, e_ls_rv);
            chk("if_rsp_data", if_rsp_data, e_if_data);
            chk("ls_rsp_data", ls_rsp_data, e_ls_data);
            if (e_if_rv) chk("if_rsp_err", if_rsp_err, e_if_err);
            if (e_ls_rv) chk("ls_rsp_err", ls_rsp_err, e_ls_err);
            chk("if_req_ready", if_req_ready, !e_busy && if_req_valid
                && (!ls_req_valid || !last_if));
            chk("ls_req_ready", ls_req_ready, !e_busy && ls_req_valid
                && (!if_req_valid || last_if));
            if (if_rsp_valid) begin
                if_rsp_n++;
                if_rsp_cyc = cyc;
                if_rsp_dat = if_rsp_data;
                if_rsp_er = if_rsp_err;
                rsp_log.push_back(1'b0);
            end
            if (ls_rsp_valid) begin
                ls_rsp_n++;
                ls_rsp_cyc = cyc;
                ls_rsp_dat = ls_rsp_data;
                ls_rsp_er = ls_rsp_err;
                rsp_log.push_back(1'b1);
            end
            if (mem_select) begin
                sel_write = mem_write;
                sel_din = mem_data_in;
                sel_addr = mem_addr;
                if (!prev_sel) begin
                    sel_n++;
                    chk("select_gap_ge2", gap >= 2, 1);
                end
                gap = 0;
            end else begin
                gap++;
            end
            if (reset) gap = 100;
            prev_sel = mem_select;
        end
    end

    task automatic issue_if(input logic [7:0] a, output int hc);
        int n0 = hs_n;
        if_req_valid = 1'b1;
        if_req_addr = a;
        hc = -1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (hs_n != n0) begin
                hc = last_hs_cyc;
                break;
            end
        end
        if_req_valid = 1'b0;
        chk("if_handshake_seen", hc >= 0, 1);
    endtask

    task automatic issue_ls(input logic [7:0] a, input logic [7:0] wd,
                            input logic [1:0] t, input logic w,
                            output int hc);
        int n0 = hs_n;
        ls_req_valid = 1'b1;
        ls_req_addr = a;
        ls_req_wdata = wd;
        ls_req_type = t;
        ls_req_write = w;
        hc = -1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (hs_n != n0) begin
                hc = last_hs_cyc;
                break;
            end
        end
        ls_req_valid = 1'b0;
        chk("ls_handshake_seen", hc >= 0, 1);
    endtask

    task automatic wait_rsp(input bit ls, input int bound, output bit got);
        int n0 = ls ? ls_rsp_n : if_rsp_n;
        got = 0;
        for (int i = 0; i < bound; i++) begin
            tick();
            #4;
            if ((ls ? ls_rsp_n : if_rsp_n) != n0) begin
                got = 1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int hc;
        bit got;
        int n0;
        int r0;
        reset = 1'b1;
        if_req_valid = 0;
        if_req_addr = 0;
        ls_req_valid = 0;
        ls_req_addr = 0;
        ls_req_wdata = 0;
        ls_req_type = 0;
        ls_req_write = 0;
        mem_data_out = 0;
        mem_data_ready = 0;
        for (int t = 0; t < 4; t++)
            for (int a = 0; a < 256; a++)
                mem_arr[t][a] = 8'($urandom);
        tick();
        tick();
        started = 1;
        reset = 1'b0;
        #4;
        chk("reset_busy", busy, 0);
        chk("reset_select", mem_select, 0);
        chk("reset_if_rsp_valid", if_rsp_valid, 0);
        chk("reset_ls_rsp_valid", ls_rsp_valid, 0);
        chk("reset_if_rsp_data", if_rsp_data, 0);

        // Fetch with a four-cycle memory.
        mem_arr[1][8'h10] = 8'hA5;
        next_lat = 4;
        issue_if(8'h10, hc);
        wait_rsp(0, 30, got);
        chk("t1_rsp_seen", got, 1);
        chk("t1_data", if_rsp_dat, 8'hA5);
        chk("t1_err", if_rsp_er, 0);
        chk("t1_latency", if_rsp_cyc - (hc - 1), 6);
        chk("t1_addr", sel_addr, 8'h10);

        // Store then load of the same location.
        next_lat = 3;
        issue_ls(8'h20, 8'h5A, 2'd0, 1'b1, hc);
        wait_rsp(1, 30, got);
        chk("t2_store_rsp_seen", got, 1);
        chk("t2_store_write", sel_write, 1);
        chk("t2_store_din", sel_din, 8'h5A);
        chk("t2_store_data", ls_rsp_dat, 8'h00);
        next_lat = 2;
        issue_ls(8'h20, 8'h00, 2'd0, 1'b0, hc);
        wait_rsp(1, 30, got);
        chk("t2_load_rsp_seen", got, 1);
        chk("t2_load_write", sel_write, 0);
        chk("t2_load_data", ls_rsp_dat, 8'h5A);
        chk("t2_load_err", ls_rsp_er, 0);

        // Both sides valid continuously: grants alternate from IF.
        do_reset();
        r0 = rsp_log.size();
        n0 = hs_n;
        if_req_valid = 1'b1;
        if_req_addr = 8'h30;
        ls_req_valid = 1'b1;
        ls_req_addr = 8'h40;
        ls_req_type = 2'd0;
        ls_req_write = 1'b0;
        for (int i = 0; i < 200 && hs_n - n0 < 4; i++) begin
            next_lat = $urandom_range(1, 5);
            tick();
        end
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        for (int i = 0; i < 40 && rsp_log.size() - r0 < 4; i++) tick();
        chk("t3_rsp_count", rsp_log.size() - r0, 4);
        if (rsp_log.size() - r0 >= 4) begin
            chk("t3_grant0", rsp_log[r0], 0);
            chk("t3_grant1", rsp_log[r0 + 1], 1);
            chk("t3_grant2", rsp_log[r0 + 2], 0);
            chk("t3_grant3", rsp_log[r0 + 3], 1);
        end

        // Reserved type: no memory access, error response.
        n0 = sel_n;
        issue_ls(8'h55, 8'h77, 2'd3, 1'b1, hc);
        wait_rsp(1, 10, got);
        chk("t4_rsp_seen", got, 1);
        chk("t4_no_select", sel_n - n0, 0);
        chk("t4_err", ls_rsp_er, 1);
        chk("t4_data", ls_rsp_dat, 8'h00);
        chk("t4_latency", ls_rsp_cyc - (hc - 1), 2);

        // Reset in the middle of ACCESS.
        next_lat = 8;
        issue_ls(8'h66, 8'h00, 2'd2, 1'b0, hc);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #4;
        chk("t5_select_dropped", mem_select, 0);
        chk("t5_busy_dropped", busy, 0);
        n0 = ls_rsp_n;
        repeat (12) tick();
        chk("t5_no_rsp", ls_rsp_n - n0, 0);
        mem_arr[1][8'h12] = 8'h3C;
        next_lat = 2;
        issue_if(8'h12, hc);
        wait_rsp(0, 30, got);
        chk("t5_fresh_rsp_seen", got, 1);
        chk("t5_fresh_data", if_rsp_dat, 8'h3C);

        // Memory never completes.
        next_noready = 1;
        n0 = if_rsp_n;
        issue_if(8'h77, hc);
        next_noready = 0;
`ifdef SPELL_MEM_TIMEOUT_EN
        wait_rsp(0, 40, got);
        chk("t6_rsp_seen", got, 1);
        chk("t6_err", if_rsp_er, 1);
        chk("t6_data", if_rsp_dat, 8'h00);
        chk("t6_abort_time", if_rsp_cyc - hc, 16);
`else
        repeat (40) tick();
        #4;
        chk("t6_no_rsp", if_rsp_n - n0, 0);
        chk("t6_still_busy", busy, 1);
        chk("t6_still_select", mem_select, 1);
        do_reset();
`endif

        // Randomized traffic with occasional resets.
        n0 = if_rsp_n + ls_rsp_n;
        for (int i = 0; i < 3000; i++) begin
            tick();
            reset = ($urandom_range(0, 299) == 0);
            if_req_valid = !reset && ($urandom_range(0, 1) == 1);
            ls_req_valid = !reset && ($urandom_range(0, 1) == 1);
            if_req_addr = 8'($urandom);
            ls_req_addr = 8'($urandom);
            ls_req_wdata = 8'($urandom);
            ls_req_type = 2'($urandom);
            ls_req_write = 1'($urandom);
            next_lat = $urandom_range(1, 6);
        end
        reset = 1'b0;
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        repeat (20) tick();
        chk("rand_activity", (if_rsp_n + ls_rsp_n - n0) > 100, 1);
        #4;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
